// File: rtl/riscv_soft_mem_arbiter_pkg.sv
// Shared constants and helpers for the tile memory arbiter.
// Requester IDs, memory op encodings and round-robin helper.
package riscv_soft_mem_arbiter_pkg;

    localparam logic [1:0] MEM_OP_READ  = 2'd0;
    localparam logic [1:0] MEM_OP_WRITE = 2'd1;
    localparam logic [2:0] MEM_TYPE_W   = 3'd2;

    typedef logic [1:0] arb_id_t;

    localparam arb_id_t ARB_ID_FETCH = 2'd0;
    localparam arb_id_t ARB_ID_DATA  = 2'd1;
    localparam arb_id_t ARB_ID_HOST  = 2'd2;

    // Next requester in round-robin order, wrapping host back to fetch.
    function automatic arb_id_t next_id(arb_id_t id);
        return (id == ARB_ID_HOST) ? ARB_ID_FETCH : arb_id_t'(id + 2'd1);
    endfunction

endpackage

// File: rtl/riscv_soft_id_fifo.sv
// Small requester-ID FIFO for in-order response routing.
// Push and pop may happen in the same cycle.
module riscv_soft_id_fifo #(
    parameter int AW = 1,
    parameter int W  = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage, no reset needed since empty guards reads
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/riscv_soft_mem_arbiter.sv
// Round-robin arbiter sharing one memory port among fetch, data, host.
// Responses return in order, routed back through an ID FIFO.
module riscv_soft_mem_arbiter
    import riscv_soft_mem_arbiter_pkg::*;
#(
    parameter int XPR_LEN      = 32,
    parameter int MAX_INFLIGHT = 2,
    parameter int ID_FIFO_AW   = 1
) (
    input  logic               clk,
    input  logic               reset,
    output logic               i_fetch_req_ready,
    input  logic               i_fetch_req_valid,
    input  logic [XPR_LEN-1:0] i_fetch_req_addr,
    output logic               i_fetch_resp_valid,
    output logic [XPR_LEN-1:0] i_fetch_resp_data,
    output logic               data_req_ready,
    input  logic               data_req_valid,
    input  logic [1:0]         data_req_op,
    input  logic [2:0]         data_req_op_type,
    input  logic [XPR_LEN-1:0] data_req_addr,
    input  logic [XPR_LEN-1:0] data_req_data,
    output logic               data_resp_valid,
    output logic [XPR_LEN-1:0] data_resp_data,
    output logic               host_req_ready,
    input  logic               host_req_valid,
    input  logic [1:0]         host_req_op,
    input  logic [2:0]         host_req_op_type,
    input  logic [XPR_LEN-1:0] host_req_addr,
    input  logic [XPR_LEN-1:0] host_req_data,
    output logic               host_resp_valid,
    output logic [XPR_LEN-1:0] host_resp_data,
    input  logic               mem_req_ready,
    output logic               mem_req_valid,
    output logic [1:0]         mem_req_op,
    output logic [2:0]         mem_req_op_type,
    output logic [XPR_LEN-1:0] mem_req_addr,
    output logic [XPR_LEN-1:0] mem_req_data,
    input  logic               mem_resp_valid,
    input  logic [XPR_LEN-1:0] mem_resp_data,
    output logic               orphan_resp_err
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);

    arb_id_t       last_grant;
    arb_id_t       grant;
    arb_id_t       c0;
    arb_id_t       c1;
    arb_id_t       c2;
    arb_id_t       fifo_head;
    logic [3:0]    valid_vec;
    logic          any_valid;
    logic          stall;
    logic          accept;
    logic          resp_pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] inflight_cnt;

    assign c0        = next_id(last_grant);
    assign c1        = next_id(c0);
    assign c2        = next_id(c1);
    assign valid_vec = {1'b0, host_req_valid, data_req_valid, i_fetch_req_valid};
    assign any_valid = |valid_vec;
    assign stall     = (inflight_cnt == CNT_MAX);

    // Round-robin search starting just after the last accepted requester
    always_comb begin
        grant = c0;
        if (valid_vec[c0])      grant = c0;
        else if (valid_vec[c1]) grant = c1;
        else if (valid_vec[c2]) grant = c2;
    end

    assign mem_req_valid = any_valid && !stall && !fifo_full;
    assign accept        = mem_req_valid && mem_req_ready;
    assign resp_pop      = mem_resp_valid && !fifo_empty;

    assign i_fetch_req_ready = mem_req_valid && mem_req_ready && (grant == ARB_ID_FETCH);
    assign data_req_ready    = mem_req_valid && mem_req_ready && (grant == ARB_ID_DATA);
    assign host_req_ready    = mem_req_valid && mem_req_ready && (grant == ARB_ID_HOST);

    // Steer the granted requester's fields onto the memory port
    always_comb begin
        mem_req_op      = MEM_OP_READ;
        mem_req_op_type = MEM_TYPE_W;
        mem_req_addr    = i_fetch_req_addr;
        mem_req_data    = '0;
        unique case (grant)
            ARB_ID_DATA: begin
                mem_req_op      = data_req_op;
                mem_req_op_type = data_req_op_type;
                mem_req_addr    = data_req_addr;
                mem_req_data    = data_req_data;
            end
            ARB_ID_HOST: begin
                mem_req_op      = host_req_op;
                mem_req_op_type = host_req_op_type;
                mem_req_addr    = host_req_addr;
                mem_req_data    = host_req_data;
            end
            default: ;
        endcase
    end

    riscv_soft_id_fifo #(
        .AW (ID_FIFO_AW),
        .W  (2)
    ) u_id_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (grant),
        .pop       (resp_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Arbitration pointer and outstanding-request count
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant   <= ARB_ID_HOST;
            inflight_cnt <= '0;
        end else begin
            if (accept) last_grant <= grant;
            unique case ({accept, resp_pop})
                2'b10:   inflight_cnt <= inflight_cnt + CW'(1);
                2'b01:   inflight_cnt <= inflight_cnt - CW'(1);
                default: inflight_cnt <= inflight_cnt;
            endcase
        end
    end

    // Register the response toward its owner and flag orphan responses
    always_ff @(posedge clk) begin
        if (reset) begin
            i_fetch_resp_valid <= 1'b0;
            data_resp_valid    <= 1'b0;
            host_resp_valid    <= 1'b0;
            i_fetch_resp_data  <= '0;
            data_resp_data     <= '0;
            host_resp_data     <= '0;
            orphan_resp_err    <= 1'b0;
        end else begin
            i_fetch_resp_valid <= 1'b0;
            data_resp_valid    <= 1'b0;
            host_resp_valid    <= 1'b0;
            if (resp_pop) begin
                unique case (fifo_head)
                    ARB_ID_DATA: begin
                        data_resp_valid <= 1'b1;
                        data_resp_data  <= mem_resp_data;
                    end
                    ARB_ID_HOST: begin
                        host_resp_valid <= 1'b1;
                        host_resp_data  <= mem_resp_data;
                    end
                    default: begin
                        i_fetch_resp_valid <= 1'b1;
                        i_fetch_resp_data  <= mem_resp_data;
                    end
                endcase
            end
            if (mem_resp_valid && fifo_empty) orphan_resp_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_riscv_soft_mem_arbiter.sv
// Directed bench for the three-way memory arbiter.
// Inputs change on negedge; outputs are sampled 1ns later.
module tb_riscv_soft_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        i_fetch_req_ready;
    logic        i_fetch_req_valid;
    logic [31:0] i_fetch_req_addr;
    logic        i_fetch_resp_valid;
    logic [31:0] i_fetch_resp_data;
    logic        data_req_ready;
    logic        data_req_valid;
    logic [1:0]  data_req_op;
    logic [2:0]  data_req_op_type;
    logic [31:0] data_req_addr;
    logic [31:0] data_req_data;
    logic        data_resp_valid;
    logic [31:0] data_resp_data;
    logic        host_req_ready;
    logic        host_req_valid;
    logic [1:0]  host_req_op;
    logic [2:0]  host_req_op_type;
    logic [31:0] host_req_addr;
    logic [31:0] host_req_data;
    logic        host_resp_valid;
    logic [31:0] host_resp_data;
    logic        mem_req_ready;
    logic        mem_req_valid;
    logic [1:0]  mem_req_op;
    logic [2:0]  mem_req_op_type;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        orphan_resp_err;

    int n_cmp;
    int n_bad;

    riscv_soft_mem_arbiter #(
        .XPR_LEN      (32),
        .MAX_INFLIGHT (2),
        .ID_FIFO_AW   (1)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .i_fetch_req_ready  (i_fetch_req_ready),
        .i_fetch_req_valid  (i_fetch_req_valid),
        .i_fetch_req_addr   (i_fetch_req_addr),
        .i_fetch_resp_valid (i_fetch_resp_valid),
        .i_fetch_resp_data  (i_fetch_resp_data),
        .data_req_ready     (data_req_ready),
        .data_req_valid     (data_req_valid),
        .data_req_op        (data_req_op),
        .data_req_op_type   (data_req_op_type),
        .data_req_addr      (data_req_addr),
        .data_req_data      (data_req_data),
        .data_resp_valid    (data_resp_valid),
        .data_resp_data     (data_resp_data),
        .host_req_ready     (host_req_ready),
        .host_req_valid     (host_req_valid),
        .host_req_op        (host_req_op),
        .host_req_op_type   (host_req_op_type),
        .host_req_addr      (host_req_addr),
        .host_req_data      (host_req_data),
        .host_resp_valid    (host_resp_valid),
        .host_resp_data     (host_resp_data),
        .mem_req_ready      (mem_req_ready),
        .mem_req_valid      (mem_req_valid),
        .mem_req_op         (mem_req_op),
        .mem_req_op_type    (mem_req_op_type),
        .mem_req_addr       (mem_req_addr),
        .mem_req_data       (mem_req_data),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_data      (mem_resp_data),
        .orphan_resp_err    (orphan_resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_fetch_req_valid = 1'b0;
        i_fetch_req_addr  = '0;
        data_req_valid    = 1'b0;
        data_req_op       = '0;
        data_req_op_type  = '0;
        data_req_addr     = '0;
        data_req_data     = '0;
        host_req_valid    = 1'b0;
        host_req_op       = '0;
        host_req_op_type  = '0;
        host_req_addr     = '0;
        host_req_data     = '0;
        mem_req_ready     = 1'b0;
        mem_resp_valid    = 1'b0;
        mem_resp_data     = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        i_fetch_req_valid = 1'b1;
        i_fetch_req_addr  = 32'h0F00;
        data_req_valid    = 1'b1;
        data_req_addr     = 32'h0D00;
        host_req_valid    = 1'b1;
        host_req_addr     = 32'h0E00;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        n_cmp++; if ({i_fetch_resp_valid, data_resp_valid, host_resp_valid} !== 3'b000) begin n_bad++; $display("FAIL reset_resp_valid got=%b exp=000", {i_fetch_resp_valid, data_resp_valid, host_resp_valid}); end
        n_cmp++; if ({i_fetch_resp_data, data_resp_data, host_resp_data} !== 96'h0) begin n_bad++; $display("FAIL reset_resp_data got=%h exp=0", {i_fetch_resp_data, data_resp_data, host_resp_data}); end
        n_cmp++; if (orphan_resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_orphan got=%b exp=0", orphan_resp_err); end
        n_cmp++; if (mem_req_valid !== 1'b1) begin n_bad++; $display("FAIL reset_req_valid got=%b exp=1", mem_req_valid); end
        n_cmp++; if (mem_req_addr !== 32'h0F00) begin n_bad++; $display("FAIL reset_fetch_prio got=%h exp=%h", mem_req_addr, 32'h0F00); end
        n_cmp++; if ({host_req_ready, data_req_ready, i_fetch_req_ready} !== 3'b000) begin n_bad++; $display("FAIL reset_ready_no_mem got=%b exp=000", {host_req_ready, data_req_ready, i_fetch_req_ready}); end
        clear_inputs();
        #1;
        n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL idle_req_valid got=%b exp=0", mem_req_valid); end
        cyc();
    endtask

    task automatic test_single_fetch();
        do_reset();
        i_fetch_req_valid = 1'b1;
        i_fetch_req_addr  = 32'h100;
        mem_req_ready     = 1'b1;
        #1;
        n_cmp++; if (mem_req_valid !== 1'b1) begin n_bad++; $display("FAIL sf_req_valid got=%b exp=1", mem_req_valid); end
        n_cmp++; if (mem_req_addr !== 32'h100) begin n_bad++; $display("FAIL sf_addr got=%h exp=%h", mem_req_addr, 32'h100); end
        n_cmp++; if (mem_req_op !== 2'd0) begin n_bad++; $display("FAIL sf_op got=%0d exp=0", mem_req_op); end
        n_cmp++; if (mem_req_op_type !== 3'd2) begin n_bad++; $display("FAIL sf_op_type got=%0d exp=2", mem_req_op_type); end
        n_cmp++; if (mem_req_data !== 32'h0) begin n_bad++; $display("FAIL sf_data got=%h exp=0", mem_req_data); end
        n_cmp++; if ({host_req_ready, data_req_ready, i_fetch_req_ready} !== 3'b001) begin n_bad++; $display("FAIL sf_ready got=%b exp=001", {host_req_ready, data_req_ready, i_fetch_req_ready}); end
        cyc();
        i_fetch_req_valid = 1'b0;
        cyc();
        cyc();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hDEADBEEF;
        #1;
        n_cmp++; if (i_fetch_resp_valid !== 1'b0) begin n_bad++; $display("FAIL sf_resp_early got=%b exp=0", i_fetch_resp_valid); end
        cyc();
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        #1;
        n_cmp++; if ({host_resp_valid, data_resp_valid, i_fetch_resp_valid} !== 3'b001) begin n_bad++; $display("FAIL sf_resp_valid got=%b exp=001", {host_resp_valid, data_resp_valid, i_fetch_resp_valid}); end
        n_cmp++; if (i_fetch_resp_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sf_resp_data got=%h exp=%h", i_fetch_resp_data, 32'hDEADBEEF); end
        cyc();
        #1;
        n_cmp++; if (i_fetch_resp_valid !== 1'b0) begin n_bad++; $display("FAIL sf_resp_pulse got=%b exp=0", i_fetch_resp_valid); end
    endtask

    task automatic test_round_robin();
        logic [1:0]  order [6];
        logic [2:0]  got_rdy;
        logic [2:0]  got_rsp;
        logic [31:0] exp_addr;
        logic [1:0]  exp_op;
        logic [31:0] got_d;
        order = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        do_reset();
        i_fetch_req_addr = 32'h1000;
        data_req_addr    = 32'h2000;
        data_req_op      = 2'd0;
        data_req_op_type = 3'd4;
        host_req_addr    = 32'h3000;
        host_req_op      = 2'd1;
        host_req_op_type = 3'd2;
        host_req_data    = 32'h55;
        mem_req_ready    = 1'b1;
        for (int j = 0; j < 8; j++) begin
            i_fetch_req_valid = (j < 6);
            data_req_valid    = (j < 6);
            host_req_valid    = (j < 6);
            mem_resp_valid    = (j >= 1 && j <= 6);
            mem_resp_data     = 32'(32'hA0 + j - 1);
            #1;
            if (j < 6) begin
                got_rdy = {host_req_ready, data_req_ready, i_fetch_req_ready};
                n_cmp++; if (got_rdy !== (3'b001 << order[j])) begin n_bad++; $display("FAIL rr_grant[%0d] got=%b exp=%b", j, got_rdy, 3'b001 << order[j]); end
                exp_addr = (order[j] == 2'd0) ? 32'h1000 : (order[j] == 2'd1) ? 32'h2000 : 32'h3000;
                exp_op   = (order[j] == 2'd2) ? 2'd1 : 2'd0;
                n_cmp++; if (mem_req_addr !== exp_addr) begin n_bad++; $display("FAIL rr_addr[%0d] got=%h exp=%h", j, mem_req_addr, exp_addr); end
                n_cmp++; if (mem_req_op !== exp_op) begin n_bad++; $display("FAIL rr_op[%0d] got=%0d exp=%0d", j, mem_req_op, exp_op); end
            end
            if (j >= 2) begin
                got_rsp = {host_resp_valid, data_resp_valid, i_fetch_resp_valid};
                n_cmp++; if (got_rsp !== (3'b001 << order[j-2])) begin n_bad++; $display("FAIL rr_resp[%0d] got=%b exp=%b", j, got_rsp, 3'b001 << order[j-2]); end
                got_d = (order[j-2] == 2'd0) ? i_fetch_resp_data : (order[j-2] == 2'd1) ? data_resp_data : host_resp_data;
                n_cmp++; if (got_d !== 32'(32'hA0 + j - 2)) begin n_bad++; $display("FAIL rr_resp_data[%0d] got=%h exp=%h", j, got_d, 32'(32'hA0 + j - 2)); end
            end
            cyc();
        end
        clear_inputs();
    endtask

    task automatic test_inflight_limit();
        do_reset();
        i_fetch_req_valid = 1'b1;
        i_fetch_req_addr  = 32'h400;
        mem_req_ready     = 1'b1;
        #1;
        n_cmp++; if (i_fetch_req_ready !== 1'b1) begin n_bad++; $display("FAIL lim_acc0 got=%b exp=1", i_fetch_req_ready); end
        cyc();
        #1;
        n_cmp++; if (i_fetch_req_ready !== 1'b1) begin n_bad++; $display("FAIL lim_acc1 got=%b exp=1", i_fetch_req_ready); end
        cyc();
        #1;
        n_cmp++; if ({mem_req_valid, i_fetch_req_ready} !== 2'b00) begin n_bad++; $display("FAIL lim_stall got=%b exp=00", {mem_req_valid, i_fetch_req_ready}); end
        cyc();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h5A;
        #1;
        n_cmp++; if (i_fetch_req_ready !== 1'b0) begin n_bad++; $display("FAIL lim_no_reuse got=%b exp=0", i_fetch_req_ready); end
        cyc();
        mem_resp_valid = 1'b0;
        #1;
        n_cmp++; if (i_fetch_req_ready !== 1'b1) begin n_bad++; $display("FAIL lim_freed got=%b exp=1", i_fetch_req_ready); end
        n_cmp++; if (i_fetch_resp_valid !== 1'b1) begin n_bad++; $display("FAIL lim_resp got=%b exp=1", i_fetch_resp_valid); end
        cyc();
        i_fetch_req_valid = 1'b1;
        #1;
        n_cmp++; if (i_fetch_req_ready !== 1'b0) begin n_bad++; $display("FAIL lim_full_again got=%b exp=0", i_fetch_req_ready); end
        clear_inputs();
        mem_resp_valid = 1'b1;
        cyc();
        cyc();
        clear_inputs();
        cyc();
    endtask

    task automatic test_ordering();
        do_reset();
        mem_req_ready  = 1'b1;
        data_req_valid = 1'b1;
        data_req_addr  = 32'h200;
        #1;
        n_cmp++; if ({data_req_ready, mem_req_addr} !== {1'b1, 32'h200}) begin n_bad++; $display("FAIL ord_data_req got=%b/%h exp=1/200", data_req_ready, mem_req_addr); end
        cyc();
        data_req_valid = 1'b0;
        host_req_valid = 1'b1;
        host_req_addr  = 32'h300;
        #1;
        n_cmp++; if ({host_req_ready, mem_req_addr} !== {1'b1, 32'h300}) begin n_bad++; $display("FAIL ord_host_req got=%b/%h exp=1/300", host_req_ready, mem_req_addr); end
        cyc();
        host_req_valid = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h11;
        cyc();
        mem_resp_data  = 32'h22;
        #1;
        n_cmp++; if ({host_resp_valid, data_resp_valid, i_fetch_resp_valid} !== 3'b010) begin n_bad++; $display("FAIL ord_first_valid got=%b exp=010", {host_resp_valid, data_resp_valid, i_fetch_resp_valid}); end
        n_cmp++; if (data_resp_data !== 32'h11) begin n_bad++; $display("FAIL ord_first_data got=%h exp=11", data_resp_data); end
        cyc();
        mem_resp_valid = 1'b0;
        #1;
        n_cmp++; if ({host_resp_valid, data_resp_valid, i_fetch_resp_valid} !== 3'b100) begin n_bad++; $display("FAIL ord_second_valid got=%b exp=100", {host_resp_valid, data_resp_valid, i_fetch_resp_valid}); end
        n_cmp++; if (host_resp_data !== 32'h22) begin n_bad++; $display("FAIL ord_second_data got=%h exp=22", host_resp_data); end
        n_cmp++; if (orphan_resp_err !== 1'b0) begin n_bad++; $display("FAIL ord_no_orphan got=%b exp=0", orphan_resp_err); end
        cyc();
    endtask

    task automatic test_orphan();
        do_reset();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h77;
        #1;
        n_cmp++; if (orphan_resp_err !== 1'b0) begin n_bad++; $display("FAIL orph_pre got=%b exp=0", orphan_resp_err); end
        cyc();
        mem_resp_valid = 1'b0;
        #1;
        n_cmp++; if ({host_resp_valid, data_resp_valid, i_fetch_resp_valid} !== 3'b000) begin n_bad++; $display("FAIL orph_resp_valid got=%b exp=000", {host_resp_valid, data_resp_valid, i_fetch_resp_valid}); end
        n_cmp++; if (orphan_resp_err !== 1'b1) begin n_bad++; $display("FAIL orph_set got=%b exp=1", orphan_resp_err); end
        for (int k = 0; k < 3; k++) begin
            cyc();
            #1;
            n_cmp++; if (orphan_resp_err !== 1'b1) begin n_bad++; $display("FAIL orph_sticky[%0d] got=%b exp=1", k, orphan_resp_err); end
        end
        cyc();
    endtask

    task automatic test_reset_mid_flight();
        do_reset();
        #1;
        n_cmp++; if (orphan_resp_err !== 1'b0) begin n_bad++; $display("FAIL rmf_orphan_clr got=%b exp=0", orphan_resp_err); end
        i_fetch_req_valid = 1'b1;
        i_fetch_req_addr  = 32'h500;
        mem_req_ready     = 1'b1;
        cyc();
        cyc();
        #1;
        n_cmp++; if (i_fetch_req_ready !== 1'b0) begin n_bad++; $display("FAIL rmf_full got=%b exp=0", i_fetch_req_ready); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        data_req_valid = 1'b1;
        data_req_addr  = 32'h600;
        host_req_valid = 1'b1;
        host_req_addr  = 32'h700;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h99;
        #1;
        n_cmp++; if ({host_req_ready, data_req_ready, i_fetch_req_ready} !== 3'b001) begin n_bad++; $display("FAIL rmf_resume got=%b exp=001", {host_req_ready, data_req_ready, i_fetch_req_ready}); end
        n_cmp++; if (mem_req_addr !== 32'h500) begin n_bad++; $display("FAIL rmf_addr got=%h exp=500", mem_req_addr); end
        cyc();
        clear_inputs();
        #1;
        n_cmp++; if (orphan_resp_err !== 1'b1) begin n_bad++; $display("FAIL rmf_late_orphan got=%b exp=1", orphan_resp_err); end
        n_cmp++; if ({host_resp_valid, data_resp_valid, i_fetch_resp_valid} !== 3'b000) begin n_bad++; $display("FAIL rmf_no_resp got=%b exp=000", {host_resp_valid, data_resp_valid, i_fetch_resp_valid}); end
        cyc();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_single_fetch();
        test_round_robin();
        test_inflight_limit();
        test_ordering();
        test_orphan();
        test_reset_mid_flight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_soft_mem_arbiter.md
Name: riscv_soft_mem_arbiter

Overview:
Shares one downstream memory request/response port among three requesters: instruction fetch, core data, and host.
- Round-robin grant.
- Up to MAX_INFLIGHT accepted-but-unanswered requests.
- Responses return in order and are routed back by a requester-ID FIFO.
- Sits between the core/host request channels and a single-ported cache or memory controller inside the tile.

Parameters:
XPR_LEN, 32, address/data width
MAX_INFLIGHT, 2, maximum outstanding requests (>=1)
ID_FIFO_AW, 1, log2 of ID FIFO depth; MAX_INFLIGHT <= 2**ID_FIFO_AW

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
i_fetch_req_ready  output  1  fetch request accepted this cycle when high with valid
i_fetch_req_valid  input  1  fetch request present
i_fetch_req_addr  input  XPR_LEN  fetch address
i_fetch_resp_valid  output  1  fetch response strobe
i_fetch_resp_data  output  XPR_LEN  fetch response data
data_req_ready / data_req_valid  output / input  1  core data handshake
data_req_op  input  2  load/store op
data_req_op_type  input  3  size/sign type
data_req_addr, data_req_data  input  XPR_LEN  address, store data
data_resp_valid  output  1;  data_resp_data  output  XPR_LEN
host_req_ready / host_req_valid / host_req_op / host_req_op_type / host_req_addr / host_req_data  as data_*
host_resp_valid  output  1;  host_resp_data  output  XPR_LEN
mem_req_ready  input  1  downstream accepts
mem_req_valid  output  1
mem_req_op  output  2;  mem_req_op_type  output  3
mem_req_addr, mem_req_data  output  XPR_LEN
mem_resp_valid  input  1;  mem_resp_data  input  XPR_LEN
orphan_resp_err  output  1  sticky: response arrived with no outstanding request

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Requester IDs: 0 = fetch, 1 = data, 2 = host.
- Grant (combinational):
  - Search IDs starting at last_grant+1 mod 3; first with valid wins.
  - last_grant reset = 2, so fetch has first priority after reset.
- Stall: stall = (inflight_cnt == MAX_INFLIGHT).
- Request side:
  - mem_req_valid = any valid && !stall.
  - mem_req_* fields muxed from the granted requester.
  - Fetch drives op = `MEM_OP_READ`, op_type = `MEM_TYPE_W`, data = 0.
  - x_req_ready = mem_req_ready && !stall && grant==x. Non-granted readies are 0.
  - Ready may depend on valid.
- Accept (mem_req_valid && mem_req_ready):
  - Push grant ID into ID FIFO.
  - last_grant <= grant.
- Response:
  - On mem_resp_valid, pop the FIFO head ID.
  - Next cycle: that requester's resp_valid=1 and resp_data = registered mem_resp_data. Latency is exactly 1 cycle.
  - Only one resp_valid high per cycle.
  - Responses have no backpressure; requesters must sink them.
- inflight_cnt:
  - +1 on accept, -1 on response; both in the same cycle → unchanged.
  - stall uses the registered count, so no same-cycle slot reuse: when full, a simultaneous response frees the slot for the next cycle.
- Orphan response: mem_resp_valid with empty FIFO →
  - No pop; no resp_valid asserted.
  - orphan_resp_err <= 1, held until reset.
- Requester holding valid while not granted: its fields are ignored; no grant is starved beyond 2 other grants.
- Reset values: all resp_valid=0, all resp_data=0, orphan_resp_err=0, FIFO empty, inflight_cnt=0, last_grant=2.
- Reset mid-operation: outstanding IDs discarded. Downstream must be reset in the same cycle; any response arriving after reset sets orphan_resp_err.

Decomposition:
- riscv_soft_constants.v gains:
  - `MEM_OP_READ` (2'd0), `MEM_OP_WRITE` (2'd1)
  - `MEM_TYPE_W` (3'd2)
  - `ARB_ID_FETCH`/`ARB_ID_DATA`/`ARB_ID_HOST` (2'd0/1/2)
- One sub-module riscv_soft_id_fifo:
  - Width 2, depth 2**ID_FIFO_AW.
  - Synchronous push/pop, empty/full flags, simultaneous push+pop legal.

Test Plan:
- Single fetch: fetch valid, addr=0x100, mem_req_ready=1 → mem_req_addr=0x100, op=0 in cycle 0; mem_resp_valid with data=0xDEADBEEF in cycle 3 → i_fetch_resp_valid=1, data=0xDEADBEEF in cycle 4; others 0.
- Round-robin: all three valid continuously, ready=1, memory responds 1 cycle after accept → grant order fetch, data, host, fetch, data, host.
- Inflight limit (MAX_INFLIGHT=2), no responses: 2 accepts, then all ready=0. Response and new request in the same cycle → third accept the following cycle, not the same one.
- Ordering: accept data (addr 0x200), then host (0x300); responses 0x11, 0x22 → data_resp_data=0x11, then host_resp_data=0x22.
- Orphan: mem_resp_valid with nothing in flight → no resp_valid; orphan_resp_err=1 and stays 1 until reset.
- Reset mid-flight: 2 outstanding, assert reset 1 cycle → readies resume next cycle with fetch priority; a late response sets orphan_resp_err.
